// File: rtl/pulse_stretcher_if.sv
// Signal bundle between event producers and the pulse stretcher.
// Carries the event strobe in and the stretched level plus status out.
interface pulse_stretcher_if #(
    parameter int PEND_W = 3
) ();
    logic              Pulse_in;
    logic              Level_out;
    logic              Busy;
    logic [PEND_W-1:0] Pending;
    logic              Dropped;

    // Event source side: drives strobes, observes the stretched output.
    modport master (
        output Pulse_in,
        input  Level_out,
        input  Busy,
        input  Pending,
        input  Dropped
    );

    // Stretcher side: consumes strobes, produces the stretched output.
    modport slave (
        input  Pulse_in,
        output Level_out,
        output Busy,
        output Pending,
        output Dropped
    );
endinterface

// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event strobes into LED-friendly levels.
// Each accepted event produces ON_TICKS cycles high followed by at least
// OFF_TICKS cycles low. A pulse seen in the last low cycle chains straight
// into the next blink.
// Optional macro PULSE_STRETCH_QUEUE_EN: events arriving while busy are
// counted in a saturating pending counter and replayed as back-to-back
// blinks. Without it, such events are discarded and Pending reads zero.
module pulse_stretcher #(
    parameter int ON_TICKS  = 2000,
    parameter int OFF_TICKS = 2000,
    parameter int CNT_W     = 14,
    parameter int PEND_W    = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    pulse_stretcher_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_OFF  = 2'b10
    } state_e;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_TICKS - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              level_q, level_d;
    logic              dropped_q, dropped_d;

    logic              busy_s;
    logic              off_end_s;
    logic              has_pend_s;

    assign busy_s    = (state_q != ST_IDLE);
    assign off_end_s = (state_q == ST_OFF) && (cnt_q == OFF_LAST);

`ifdef PULSE_STRETCH_QUEUE_EN
    localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] pending_q, pending_d;
    logic              inc_s;
    logic              dec_s;

    assign has_pend_s = (pending_q != {PEND_W{1'b0}});
    // A pulse in the last low cycle with an empty queue is used directly, not queued.
    assign inc_s      = bus.Pulse_in && busy_s && !(off_end_s && !has_pend_s);
    assign dec_s      = off_end_s && has_pend_s;

    // Pending counter update with saturation and drop reporting.
    always_comb begin
        pending_d = pending_q;
        dropped_d = 1'b0;
        if (inc_s && dec_s) begin
            pending_d = pending_q;
        end else if (inc_s) begin
            if (pending_q == PEND_MAX) begin
                pending_d = pending_q;
                dropped_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (dec_s) begin
            pending_d = pending_q - PEND_W'(1);
        end else begin
            pending_d = pending_q;
        end
    end

    // Pending counter register; cleared immediately by reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pending_q <= {PEND_W{1'b0}};
        end else begin
            pending_q <= pending_d;
        end
    end

    assign bus.Pending = pending_q;
`else
    assign has_pend_s = 1'b0;

    // Without a queue, any pulse while busy is lost unless it lands on the last low cycle.
    always_comb begin
        dropped_d = 1'b0;
        if (bus.Pulse_in && busy_s && !off_end_s) begin
            dropped_d = 1'b1;
        end else begin
            dropped_d = 1'b0;
        end
    end

    assign bus.Pending = {PEND_W{1'b0}};
`endif

    // Blink sequencer: next state, tick counter and output level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.Pulse_in) begin
                    state_d = ST_ON;
                    cnt_d   = {CNT_W{1'b0}};
                    level_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    level_d = 1'b0;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d = ST_OFF;
                    cnt_d   = {CNT_W{1'b0}};
                    level_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    level_d = 1'b1;
                end
            end
            ST_OFF: begin
                if (cnt_q == OFF_LAST) begin
                    if (has_pend_s || bus.Pulse_in) begin
                        state_d = ST_ON;
                        cnt_d   = {CNT_W{1'b0}};
                        level_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                        level_d = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    level_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                level_d = 1'b0;
            end
        endcase
    end

    // Sequencer and output registers; reset aborts any blink in progress.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            level_q   <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.Level_out = level_q;
    assign bus.Busy      = busy_s;
    assign bus.Dropped   = dropped_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher with ON_TICKS=4, OFF_TICKS=3, PEND_W=2.
// Expected traces follow PULSE_STRETCH_QUEUE_EN, matching the build of the DUT.
// Trace index i is the observation 1 time unit after the i-th clock edge,
// with Pulse_in[i] being the value sampled by that edge.
module tb_pulse_stretcher;

    localparam int ON_T  = 4;
    localparam int OFF_T = 3;
    localparam int CW    = 3;
    localparam int PW    = 2;

    logic CLK;
    logic RESET;
    int   n_cmp;
    int   n_bad;

    pulse_stretcher_if #(.PEND_W(PW)) bus ();

    pulse_stretcher #(
        .ON_TICKS  (ON_T),
        .OFF_TICKS (OFF_T),
        .CNT_W     (CW),
        .PEND_W    (PW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic test_reset();
        RESET        = 1'b1;
        bus.Pulse_in = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if ({bus.Level_out, bus.Busy, bus.Pending, bus.Dropped} !== 5'b00000) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got L=%b B=%b P=%0d D=%b want all zero",
                         i, bus.Level_out, bus.Busy, bus.Pending, bus.Dropped);
            end
        end
        RESET = 1'b0;
        @(posedge CLK); #1;
        n_cmp++;
        if (bus.Level_out !== 1'b1 || bus.Busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_first_pulse: got L=%b B=%b want L=1 B=1", bus.Level_out, bus.Busy);
        end
        bus.Pulse_in = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        n_cmp++;
        if (bus.Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_drain: got Busy=%b want 0", bus.Busy);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 9; i++) begin
            bus.Pulse_in = (i == 0);
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.Level_out !== (i < 4) || bus.Busy !== (i < 7) ||
                bus.Pending !== 2'd0 || bus.Dropped !== 1'b0) begin
                n_bad++;
                $display("FAIL single[%0d]: got L=%b B=%b P=%0d D=%b want L=%b B=%b P=0 D=0",
                         i, bus.Level_out, bus.Busy, bus.Pending, bus.Dropped, (i < 4), (i < 7));
            end
        end
        bus.Pulse_in = 1'b0;
    endtask

    // Pulses at i=0..3: one start plus three during the first ON.
    task automatic test_queue3();
        logic [31:0] pin, el, eb, ed;
        int          ep[32];
        int          n;
`ifdef PULSE_STRETCH_QUEUE_EN
        n = 30;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i <= 3);
            el[i]  = (i < 28) && ((i % 7) < 4);
            eb[i]  = (i < 28);
            ed[i]  = 1'b0;
            ep[i]  = (i <= 3) ? i : ((i >= 21) ? 0 : 3 - i / 7);
        end
`else
        n = 10;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i <= 3);
            el[i]  = (i < 4);
            eb[i]  = (i < 7);
            ed[i]  = (i >= 1) && (i <= 3);
            ep[i]  = 0;
        end
`endif
        for (int i = 0; i < n; i++) begin
            bus.Pulse_in = pin[i];
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.Level_out !== el[i] || bus.Busy !== eb[i] ||
                bus.Pending !== PW'(ep[i]) || bus.Dropped !== ed[i]) begin
                n_bad++;
                $display("FAIL queue3[%0d]: got L=%b B=%b P=%0d D=%b want L=%b B=%b P=%0d D=%b",
                         i, bus.Level_out, bus.Busy, bus.Pending, bus.Dropped, el[i], eb[i], ep[i], ed[i]);
            end
        end
        bus.Pulse_in = 1'b0;
    endtask

    // Pulses at i=0..5: queue fills to 3, the last two events are dropped.
    task automatic test_saturate();
        logic [31:0] pin, el, eb, ed;
        int          ep[32];
        int          n;
`ifdef PULSE_STRETCH_QUEUE_EN
        n = 30;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i <= 5);
            el[i]  = (i < 28) && ((i % 7) < 4);
            eb[i]  = (i < 28);
            ed[i]  = (i == 4) || (i == 5);
            ep[i]  = (i <= 3) ? i : ((i >= 21) ? 0 : 3 - i / 7);
        end
`else
        n = 10;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i <= 5);
            el[i]  = (i < 4);
            eb[i]  = (i < 7);
            ed[i]  = (i >= 1) && (i <= 5);
            ep[i]  = 0;
        end
`endif
        for (int i = 0; i < n; i++) begin
            bus.Pulse_in = pin[i];
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.Level_out !== el[i] || bus.Busy !== eb[i] ||
                bus.Pending !== PW'(ep[i]) || bus.Dropped !== ed[i]) begin
                n_bad++;
                $display("FAIL saturate[%0d]: got L=%b B=%b P=%0d D=%b want L=%b B=%b P=%0d D=%b",
                         i, bus.Level_out, bus.Busy, bus.Pending, bus.Dropped, el[i], eb[i], ep[i], ed[i]);
            end
        end
        bus.Pulse_in = 1'b0;
    endtask

    // i=7 is the last OFF cycle of the first blink.
    task automatic test_last_off();
        logic [31:0] pin, el, eb, ed;
        int          ep[32];
        int          n;
        // Part A: empty queue, pulse in the last OFF cycle chains a second blink.
        n = 16;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i == 0) || (i == 7);
            el[i]  = (i < 14) && ((i % 7) < 4);
            eb[i]  = (i < 14);
            ed[i]  = 1'b0;
            ep[i]  = 0;
        end
        for (int i = 0; i < n; i++) begin
            bus.Pulse_in = pin[i];
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.Level_out !== el[i] || bus.Busy !== eb[i] ||
                bus.Pending !== PW'(ep[i]) || bus.Dropped !== ed[i]) begin
                n_bad++;
                $display("FAIL last_off_a[%0d]: got L=%b B=%b P=%0d D=%b want L=%b B=%b P=%0d D=%b",
                         i, bus.Level_out, bus.Busy, bus.Pending, bus.Dropped, el[i], eb[i], ep[i], ed[i]);
            end
        end
        // Part B: one event already queued when the last-cycle pulse arrives.
`ifdef PULSE_STRETCH_QUEUE_EN
        n = 23;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i == 0) || (i == 1) || (i == 7);
            el[i]  = (i < 21) && ((i % 7) < 4);
            eb[i]  = (i < 21);
            ed[i]  = 1'b0;
            ep[i]  = ((i >= 1) && (i <= 13)) ? 1 : 0;
        end
`else
        n = 16;
        for (int i = 0; i < 32; i++) begin
            pin[i] = (i == 0) || (i == 1) || (i == 7);
            el[i]  = (i < 14) && ((i % 7) < 4);
            eb[i]  = (i < 14);
            ed[i]  = (i == 1);
            ep[i]  = 0;
        end
`endif
        for (int i = 0; i < n; i++) begin
            bus.Pulse_in = pin[i];
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.Level_out !== el[i] || bus.Busy !== eb[i] ||
                bus.Pending !== PW'(ep[i]) || bus.Dropped !== ed[i]) begin
                n_bad++;
                $display("FAIL last_off_b[%0d]: got L=%b B=%b P=%0d D=%b want L=%b B=%b P=%0d D=%b",
                         i, bus.Level_out, bus.Busy, bus.Pending, bus.Dropped, el[i], eb[i], ep[i], ed[i]);
            end
        end
        bus.Pulse_in = 1'b0;
    endtask

    task automatic test_reset_mid();
        int exp_p;
        for (int i = 0; i < 3; i++) begin
            bus.Pulse_in = 1'b1;
            @(posedge CLK); #1;
        end
        bus.Pulse_in = 1'b0;
`ifdef PULSE_STRETCH_QUEUE_EN
        exp_p = 2;
`else
        exp_p = 0;
`endif
        n_cmp++;
        if (bus.Level_out !== 1'b1 || bus.Pending !== PW'(exp_p)) begin
            n_bad++;
            $display("FAIL reset_mid_pre: got L=%b P=%0d want L=1 P=%0d", bus.Level_out, bus.Pending, exp_p);
        end
        RESET = 1'b1;
        #1;
        n_cmp++;
        if ({bus.Level_out, bus.Busy, bus.Pending, bus.Dropped} !== 5'b00000) begin
            n_bad++;
            $display("FAIL reset_mid_async: got L=%b B=%b P=%0d D=%b want all zero",
                     bus.Level_out, bus.Busy, bus.Pending, bus.Dropped);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            n_cmp++;
            if (bus.Level_out !== 1'b0 || bus.Busy !== 1'b0 || bus.Pending !== 2'd0) begin
                n_bad++;
                $display("FAIL reset_mid_after[%0d]: got L=%b B=%b P=%0d want 0 0 0",
                         i, bus.Level_out, bus.Busy, bus.Pending);
            end
        end
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        RESET        = 1'b1;
        bus.Pulse_in = 1'b0;
        test_reset();
        test_single();
        test_queue3();
        test_saturate();
        test_last_off();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Inverse of the button debouncer: turns single-cycle event pulses into held output levels.
- Each accepted pulse drives Level_out high for a fixed ON time, followed by a guaranteed low gap.
- The output is therefore clean enough for an LED, and a downstream debouncer on the same tick clock registers one press per pulse.
- Sits between game logic (move/error strobes) and board LEDs or an inter-board line. Runs on the slow tick clock, about 24.4 kHz.

Parameters:
- ON_TICKS, 2000: Level_out high time in CLK cycles; must be ≥ 1 (about 0.08 s at 24.4 kHz).
- OFF_TICKS, 2000: minimum low gap between consecutive blinks in CLK cycles; must be ≥ 1.
- CNT_W, 14: width of the tick counter; must hold max(ON_TICKS, OFF_TICKS) - 1.
- PEND_W, 3: width of the pending-pulse counter; saturates at 2^PEND_W - 1.

Ports:
- CLK  in  1  tick clock
- RESET  in  1  asynchronous, active-high reset
- Pulse_in  in  1  event strobe, sampled every CLK edge; each high cycle is one event
- Level_out  out  1  registered stretched output
- Busy  out  1  high in ON or OFF state
- Pending  out  PEND_W  queued events not yet shown (all zero without the macro)
- Dropped  out  1  one-cycle pulse when an event is discarded

Behaviour:
- Reset (already decided): RESET is asynchronous, active-high; clock is CLK.
- On reset: state IDLE, I=0, Pending=0, Level_out=0, Busy=0, Dropped=0. Takes effect immediately, including mid-blink; Level_out drops with no completion of the blink.
- All outputs are registered. Busy is decoded from the state register.
- States: IDLE, ON, OFF.
- IDLE:
  - If Pulse_in: go to ON, set Level_out=1, I=0. Level_out is high starting from the same edge that samples Pulse_in (zero-cycle latency, registered).
  - Otherwise stay in IDLE.
- ON:
  - I increments each cycle.
  - When I==ON_TICKS-1: go to OFF, set Level_out=0, I=0.
  - Level_out is therefore high exactly ON_TICKS cycles.
- OFF:
  - I increments each cycle.
  - When I==OFF_TICKS-1:
    - If Pending>0 or Pulse_in is high this cycle: go to ON, set Level_out=1, I=0.
    - Otherwise go to IDLE.
  - The low gap is therefore exactly OFF_TICKS cycles.
- Pending update, each cycle: Pending_next = Pending + inc - dec.
  - inc = Pulse_in while in ON or OFF, excluding a pulse consumed directly at the OFF end with Pending==0.
  - dec = 1 when a blink starts from OFF using a queued event.
  - Simultaneous arrival and consumption leaves Pending unchanged.
- Saturation:
  - If inc would exceed 2^PEND_W-1, Pending holds and Dropped=1 for one cycle.
  - Dropped otherwise returns to 0 the next cycle.
- Consecutive Pulse_in high cycles count as separate events; there is no edge detection.
- Counter wrap never occurs: I is always cleared on state change.

Optional Feature:
- Macro PULSE_STRETCH_QUEUE_EN.
- Defined: pending queue as described above.
- Undefined:
  - No queue; Pending is tied to 0.
  - Any Pulse_in while Busy is discarded with Dropped=1, except a pulse in the last OFF cycle, which starts the next blink.
  - The pending counter logic is not synthesized.

Test Plan (ON_TICKS=4, OFF_TICKS=3, PEND_W=2, macro defined unless noted):
- Assert RESET for 2 cycles with Pulse_in=1 → Level_out=0, Busy=0, Pending=0, Dropped=0 throughout; after release, first sampled pulse starts a blink.
- Single Pulse_in in IDLE → Level_out high exactly 4 cycles then low; Busy high 7 cycles; back to IDLE; Pending stays 0.
- 3 pulses during first ON → Pending reaches 3; 4 blinks total, each 4 high with exactly 3 low cycles between; Pending decrements 3→2→1→0 at each blink start.
- 5 pulses during first ON → Pending saturates at 3; Dropped pulses exactly twice; 4 blinks total.
- Pulse_in in the last OFF cycle with Pending=0 → next ON begins on the following edge and Pending stays 0. Repeat with Pending=1 → blink starts and Pending stays 1.
- RESET mid-ON with Pending=2 → Level_out=0 and Pending=0 immediately, no further blinks. Macro undefined: pulse during ON → Dropped=1 for one cycle, only 1 blink.
